// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - live-key / song-ROM note scheduler; NOTE_SCHEDULER_LOOP_EN repeats the song
module note_scheduler #(
    parameter int BEAT_TICKS = 25000000,
    parameter int GAP_TICKS  = 2500000,
    parameter int SONG_DEPTH = 16,
    localparam int AW        = $clog2(SONG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    key,
    input  logic          play,
    input  logic          stop,
    output logic [AW-1:0] song_addr,
    input  logic [5:0]    song_data,
    output logic [3:0]    note,
    output logic          busy
);

    // Counter must hold the longest note (4 beats) and the gap, minus one.
    localparam int DUR_MAX = 4 * BEAT_TICKS;
    localparam int CW      = $clog2((DUR_MAX > GAP_TICKS) ? DUR_MAX : GAP_TICKS) + 1;

    localparam logic [2:0] S_LIVE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [3:0] NOTE_NONE = 4'd8;
    localparam logic [3:0] CODE_END  = 4'hF;

`ifdef NOTE_SCHEDULER_LOOP_EN
    // Looping: the end of the song restarts the fetch from address 0.
    localparam logic [2:0] END_STATE = S_FETCH;
    localparam logic       END_BUSY  = 1'b1;
`else
    // One-shot: the end of the song hands control back to the live keys.
    localparam logic [2:0] END_STATE = S_LIVE;
    localparam logic       END_BUSY  = 1'b0;
`endif

    logic [2:0]    r_state;
    logic [3:0]    r_note;
    logic          r_busy;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_cnt;

    logic [3:0]    w_live_note;
    logic [3:0]    w_code;
    logic [1:0]    w_beats;
    logic [CW-1:0] w_dur;
    logic [3:0]    w_song_note;
    logic          w_last;

    assign w_code      = song_data[5:2];
    assign w_beats     = song_data[1:0];
    assign w_dur       = CW'((int'(w_beats) + 1) * BEAT_TICKS - 1);
    assign w_song_note = (w_code <= 4'd7) ? w_code : NOTE_NONE;
    assign w_last      = (r_addr == AW'(SONG_DEPTH - 1));

    // Lowest pressed key wins; no key pressed means silence.
    always_comb begin
        w_live_note = NOTE_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (key[i]) begin
                w_live_note = 4'(i);
            end
        end
    end

    // Scheduler FSM; note/busy/address are registered with the state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LIVE;
            r_note  <= NOTE_NONE;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else if (stop && (r_state != S_LIVE)) begin
            r_state <= S_LIVE;
            r_note  <= NOTE_NONE;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_LIVE: begin
                    if (play && !stop) begin
                        r_state <= S_FETCH;
                        r_note  <= NOTE_NONE;
                        r_busy  <= 1'b1;
                        r_addr  <= '0;
                    end else begin
                        r_note  <= w_live_note;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                    r_note  <= NOTE_NONE;
                end
                S_WAIT: begin
                    if (w_code == CODE_END) begin
                        r_state <= END_STATE;
                        r_busy  <= END_BUSY;
                        r_note  <= NOTE_NONE;
                        r_addr  <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_PLAY;
                        r_note  <= w_song_note;
                        r_cnt   <= w_dur;
                    end
                end
                S_PLAY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_GAP;
                        r_note  <= NOTE_NONE;
                        r_cnt   <= CW'(GAP_TICKS - 1);
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt   <= r_cnt - 1'b1;
                    end else if (w_last) begin
                        r_state <= END_STATE;
                        r_busy  <= END_BUSY;
                        r_note  <= NOTE_NONE;
                        r_addr  <= '0;
                    end else begin
                        r_state <= S_FETCH;
                        r_addr  <= r_addr + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_LIVE;
                    r_note  <= NOTE_NONE;
                    r_busy  <= 1'b0;
                    r_addr  <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign song_addr = r_addr;
    assign note      = r_note;
    assign busy      = r_busy;

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter BEAT_TICKS, default 25000000, clk cycles per beat (>=2).
REQ-002 Parameter GAP_TICKS, default 2500000, silent clk cycles between song notes (>=1).
REQ-003 Parameter SONG_DEPTH, default 16, song ROM entries (power of 2); AW = log2(SONG_DEPTH).
REQ-004 Port clk, input, 1, system clock; all logic on rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port key, input, 8, live keys (already synchronised and debounced); bit i requests note code i.
REQ-007 Port play, input, 1, one-cycle start-playback pulse.
REQ-008 Port stop, input, 1, one-cycle abort-playback pulse.
REQ-009 Port song_addr, output, AW, song ROM read address.
REQ-010 Port song_data, input, 6, ROM word {code[5:2], beats[1:0]}, valid exactly 1 cycle after song_addr changes.
REQ-011 Port note, output, 4, note code to LED/tone datapath: 0=C5,1=B,2=A,3=G,4=F,5=E,6=D,7=C4,8=none.
REQ-012 Port busy, output, 1, high whenever state is not LIVE.

Function
REQ-013 FSM states shall be LIVE, FETCH, WAIT, PLAY, GAP.
REQ-014 LIVE: note = lowest set index of key (key=8'h00 -> 8), registered with 1-cycle latency; song_addr held at 0.
REQ-015 LIVE + play -> FETCH with song_addr=0; play in any other state shall be ignored.
REQ-016 FETCH: one cycle, note=8, -> WAIT.
REQ-017 WAIT: one cycle; sample song_data; code<=7 -> PLAY with note=code and duration (beats+1)*BEAT_TICKS cycles; code=4'hF (end marker) -> end-of-song handling (REQ-021); codes 8..14 treated as rest (note=8, duration as for a note).
REQ-018 PLAY: note held for exact duration, duration counter wide enough for 4*BEAT_TICKS, then -> GAP.
REQ-019 GAP: note=8 for exactly GAP_TICKS cycles, then song_addr increments and -> FETCH.
REQ-020 Address wrap: GAP completing at song_addr=SONG_DEPTH-1 shall behave as end of song.
REQ-021 End of song (without LOOP_EN): -> LIVE, song_addr=0; first live note appears on the following cycle.
REQ-022 stop in any non-LIVE state -> LIVE next cycle, note=8 that cycle, counters cleared; stop in LIVE has no effect.
REQ-023 play and stop in the same cycle: stop wins; play shall not start playback.
REQ-024 key changes during playback shall be ignored.
REQ-025 busy and note are registered outputs; no combinational path from any input to any output.

Reset
REQ-026 rst asserted at any time, including mid-note, shall force state=LIVE, note=8, song_addr=0, busy=0, all counters 0, asynchronously.
REQ-027 After rst deassertion, first live note shall be registered on the first clk edge.

Configuration
REQ-028 Macro NOTE_SCHEDULER_LOOP_EN: when defined, end of song (marker or wrap) shall set song_addr=0 and go to FETCH, repeating until stop or rst; when undefined, REQ-021 applies.

Verification (BEAT_TICKS=4, GAP_TICKS=2, SONG_DEPTH=16)
REQ-029 key=8'b0001_0100 in LIVE -> note=2 one cycle later; key=0 -> note=8; busy=0 throughout.
REQ-030 ROM[0]={3,beats 1}, ROM[1]=end marker; pulse play -> FETCH, WAIT, note=3 for exactly 8 cycles, note=8 for 2 cycles, fetch addr 1, back to LIVE; busy high from cycle after play until return.
REQ-031 Pulse stop mid-PLAY of ROM[0] -> next cycle note=8, busy=0, song_addr=0; subsequent key=8'h80 -> note=7.
REQ-032 play and stop asserted together in LIVE -> busy stays 0; play pulse during PLAY -> no restart, timing unchanged.
REQ-033 All 16 ROM entries valid notes, beats=0 -> each note 4 cycles plus 2-cycle gap, after entry 15 return to LIVE (loop to addr 0 with NOTE_SCHEDULER_LOOP_EN defined).
REQ-034 rst asserted mid-GAP -> outputs at reset values immediately, without waiting for a clk edge; play after deassertion restarts from addr 0.
